mem_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency unified memory between the instruction-fetch

---
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Lets the CPU instruction-fetch port (I) and load/store port (D)
//            share one single-ported, fixed-latency unified memory. Each grant
//            issues exactly one memory access. For reads, the block counts the
//            memory latency and then returns the data to the winning port with
//            a one-cycle valid pulse.
// Config   : ARB_RR_EN - when defined, a tie between I and D is resolved
//            round-robin against the last grant. When undefined, D always
//            wins a tie (a load/store is older in program order than a fetch).
// Ports    : clk, rst_n             clock, async active-low reset
//            i_req/i_addr           fetch request (always a read), held until i_valid
//            i_rdata/i_valid        fetch data, one-cycle completion pulse
//            d_req/d_wr/d_addr/
//            d_wdata                load/store request, held until d_valid
//            d_rdata/d_valid        load data, one-cycle completion pulse
//            mem_enable/mem_wr/
//            mem_addr/mem_wdata     one-cycle access strobe and registered access
//            mem_rdata              read data, valid MEM_LAT cycles after the strobe
//            busy                   high whenever a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4     // legal range 1..15
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction-fetch port
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   // load/store port
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   // unified memory
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              busy
);

   // Read data is captured on the last WAIT cycle. The counter is loaded in
   // ISSUE, so it starts one below the latency.
   localparam logic [3:0] C_WAIT_INIT = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Transaction context, frozen from the IDLE sample until RESP completes
   logic                r_win_d;     // 1 = D port owns the transaction
   logic                r_wr;        // 1 = store
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [3:0]          r_cnt;

   // Per-port read data, each held until that port's next read completes
   logic [DATA_W-1:0]   r_i_rdata;
   logic [DATA_W-1:0]   r_d_rdata;

   logic                w_any_req;
   logic                w_pick_d;
   logic                w_grant;

   assign w_any_req = i_req | d_req;
   assign w_grant   = (r_state == S_IDLE) && w_any_req;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
`ifdef ARB_RR_EN
   // Remembers which port received the most recent grant. It updates on every
   // grant, including uncontested grants, so a port that just had a turn
   // yields on the next tie. It resets to D, so the first tie goes to I.
   logic r_last_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_d <= 1'b1;
      end else if (w_grant) begin
         r_last_d <= w_pick_d;
      end
   end

   // A single requester always wins. On a tie, the port that was not
   // granted last time wins.
   assign w_pick_d = d_req & (~i_req | ~r_last_d);
`else
   // Fixed priority: D wins any tie.
   assign w_pick_d = d_req;
`endif

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      i_valid     = 1'b0;
      d_valid     = 1'b0;
      busy        = 1'b1;

      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_any_req) begin
               w_state_nxt = S_ISSUE;
            end
         end

         S_ISSUE: begin
            mem_enable  = 1'b1;
            mem_wr      = r_wr;
            // A store needs no data back, so it skips the latency wait.
            w_state_nxt = r_wr ? S_RESP : S_WAIT;
         end

         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_RESP;
            end
         end

         S_RESP: begin
            i_valid     = ~r_win_d;
            d_valid     = r_win_d;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request capture: latch the winner's context at the IDLE sample
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_d <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant) begin
         r_win_d <= w_pick_d;
         // Only D issues stores. A fetch is always a read.
         r_wr    <= w_pick_d & d_wr;
         r_addr  <= w_pick_d ? d_addr : i_addr;
         r_wdata <= w_pick_d ? d_wdata : '0;
      end
   end

   // ------------------------------------------------------------------------
   // Latency counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
      end else if (r_state == S_ISSUE) begin
         r_cnt <= C_WAIT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Read-data capture. Only the winner's register is written; the other
   // port's data is left untouched.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else if ((r_state == S_WAIT) && (r_cnt == 4'd0)) begin
         if (r_win_d) begin
            r_d_rdata <= mem_rdata;
         end else begin
            r_i_rdata <= mem_rdata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registered datapath outputs
   // ------------------------------------------------------------------------
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter. Each stimulus step pushes the
//            expected memory accesses and port responses into queues. A
//            monitor pops an entry and compares it whenever the DUT raises
//            mem_enable or a valid pulse. The bench models the unified memory
//            with a fixed read latency.
// Config   : ARB_RR_EN selects the expected arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int MEM_LAT = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_req, d_req, d_wr;
   logic [15:0]       i_addr, d_addr, d_wdata;
   logic [15:0]       i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic              i_valid, d_valid, mem_enable, mem_wr, busy;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model. Read data appears MEM_LAT cycles after the strobe cycle.
   // Cycles with no read in flight carry a poison value.
   logic [15:0] mem [0:65535];
   logic [15:0] dl  [0:MEM_LAT-1];
   always @(posedge clk) begin
      if (!rst_n) mem[16'h0010] <= 16'hA5A5;
      else if (mem_enable && mem_wr) mem[mem_addr] <= mem_wdata;
      dl[0] <= (mem_enable && !mem_wr) ? mem[mem_addr] : 16'hDEAD;
      for (int k = 1; k < MEM_LAT; k++) dl[k] <= dl[k-1];
   end
   assign mem_rdata = dl[MEM_LAT-1];

   typedef struct { logic is_d; logic chk_data; logic [15:0] data; int cyc; } resp_t;
   typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; int cyc; } acc_t;
   resp_t rq[$];
   acc_t  aq[$];
   resp_t mon_r;
   acc_t  mon_a;
   int total = 0;
   int bad = 0;
   int t0 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_acc(input logic wr, input logic [15:0] a, input logic [15:0] wd, input int c);
      acc_t e;
      e.wr = wr; e.addr = a; e.wdata = wd; e.cyc = c;
      aq.push_back(e);
   endtask

   task automatic push_resp(input logic is_d, input logic cd, input logic [15:0] d, input int c);
      resp_t e;
      e.is_d = is_d; e.chk_data = cd; e.data = d; e.cyc = c;
      rq.push_back(e);
   endtask

   // Monitor: compares every access strobe and every completion pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_enable) begin
            if (aq.size() == 0) chk("unexpected_mem_enable", 32'(mem_enable), 32'd0);
            else begin
               mon_a = aq.pop_front();
               chk("acc_wr", 32'(mem_wr), 32'(mon_a.wr));
               chk("acc_addr", 32'(mem_addr), 32'(mon_a.addr));
               if (mon_a.wr) chk("acc_wdata", 32'(mem_wdata), 32'(mon_a.wdata));
               chk("acc_cycle", 32'(cyc), 32'(mon_a.cyc));
            end
         end
         if (i_valid || d_valid) begin
            if (rq.size() == 0) chk("unexpected_valid", 32'({i_valid, d_valid}), 32'd0);
            else begin
               mon_r = rq.pop_front();
               chk("resp_port", 32'({i_valid, d_valid}), mon_r.is_d ? 32'd1 : 32'd2);
               if (mon_r.chk_data)
                  chk("resp_data", mon_r.is_d ? 32'(d_rdata) : 32'(i_rdata), 32'(mon_r.data));
               chk("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
      t0 = cyc;
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rq.size() == 0 && aq.size() == 0 && !busy) break;
      end
      total++;
      if (k == 200) begin
         bad++;
         $display("FAIL drain_timeout: actual=%0d/%0d pending required=0/0", rq.size(), aq.size());
      end
   endtask

   task automatic run_i(input logic [15:0] a);
      int k;
      i_req = 1'b1; i_addr = a;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (i_valid) break;
      end
      i_req = 1'b0;
      if (k == 60) begin
         total++; bad++;
         $display("FAIL i_timeout: actual=no i_valid required=i_valid within 60 cycles");
      end
   endtask

   task automatic run_d(input logic wr, input logic [15:0] a, input logic [15:0] wd);
      int k;
      d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
      for (k = 0; k < 60; k++) begin
         @(negedge clk);
         if (d_valid) break;
      end
      d_req = 1'b0;
      if (k == 60) begin
         total++; bad++;
         $display("FAIL d_timeout: actual=no d_valid required=d_valid within 60 cycles");
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_i_valid"},    32'(i_valid),    32'd0);
      chk({tag, "_d_valid"},    32'(d_valid),    32'd0);
      chk({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
      chk({tag, "_mem_wr"},     32'(mem_wr),     32'd0);
      chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
      chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_i_rdata"},    32'(i_rdata),    32'd0);
      chk({tag, "_d_rdata"},    32'(d_rdata),    32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] order;
      int n, k;
      i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // 1: single fetch of 0x0010
      sync();
      push_acc(1'b0, 16'h0010, 16'h0, t0 + 1);
      push_resp(1'b0, 1'b1, 16'hA5A5, t0 + MEM_LAT + 2);
      run_i(16'h0010);
      wait_drain();

      // 2: store then load of 0x0100
      sync();
      push_acc(1'b1, 16'h0100, 16'h1234, t0 + 1);
      push_resp(1'b1, 1'b0, 16'h0, t0 + 2);
      run_d(1'b1, 16'h0100, 16'h1234);
      wait_drain();
      chk("d_rdata_after_store", 32'(d_rdata), 32'd0);
      sync();
      push_acc(1'b0, 16'h0100, 16'h0, t0 + 1);
      push_resp(1'b1, 1'b1, 16'h1234, t0 + MEM_LAT + 2);
      run_d(1'b0, 16'h0100, 16'h0);
      wait_drain();
      chk("i_rdata_held", 32'(i_rdata), 32'hA5A5);

      // 3: simultaneous fetch and load (last grant so far is D)
      sync();
`ifdef ARB_RR_EN
      push_acc(1'b0, 16'h0010, 16'h0, t0 + 1);
      push_acc(1'b0, 16'h0100, 16'h0, t0 + 8);
      push_resp(1'b0, 1'b1, 16'hA5A5, t0 + 6);
      push_resp(1'b1, 1'b1, 16'h1234, t0 + 13);
`else
      push_acc(1'b0, 16'h0100, 16'h0, t0 + 1);
      push_acc(1'b0, 16'h0010, 16'h0, t0 + 8);
      push_resp(1'b1, 1'b1, 16'h1234, t0 + 6);
      push_resp(1'b0, 1'b1, 16'hA5A5, t0 + 13);
`endif
      fork
         run_i(16'h0010);
         run_d(1'b0, 16'h0100, 16'h0);
      join
      wait_drain();

      // 4: both ports request continuously for four grants
`ifdef ARB_RR_EN
      order = 4'b1010;   // I, D, I, D
`else
      order = 4'b1111;   // D wins every tie
`endif
      sync();
      for (int j = 0; j < 4; j++) begin
         push_acc(1'b0, order[j] ? 16'h0100 : 16'h0010, 16'h0, t0 + 1 + 7 * j);
         push_resp(order[j], 1'b1, order[j] ? 16'h1234 : 16'hA5A5, t0 + 6 + 7 * j);
      end
      i_req = 1; i_addr = 16'h0010; d_req = 1; d_wr = 0; d_addr = 16'h0100;
      n = 0;
      for (k = 0; k < 200 && n < 4; k++) begin
         @(negedge clk);
         if (i_valid || d_valid) n++;
      end
      i_req = 0; d_req = 0;
      chk("grant_count", 32'(n), 32'd4);
      wait_drain();

      // 5: reset during WAIT of a fetch
      sync();
      push_acc(1'b0, 16'h0010, 16'h0, t0 + 1);
      i_req = 1; i_addr = 16'h0010;
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      check_zero("midrst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_drain();
      sync();
      push_acc(1'b0, 16'h0010, 16'h0, t0 + 1);
      push_resp(1'b0, 1'b1, 16'hA5A5, t0 + MEM_LAT + 2);
      run_i(16'h0010);
      wait_drain();

      // 6: d_req dropped in cycle 2 of a load; inputs change mid-transaction
      sync();
      push_acc(1'b0, 16'h0010, 16'h0, t0 + 1);
      push_resp(1'b1, 1'b1, 16'hA5A5, t0 + MEM_LAT + 2);
      d_req = 1; d_wr = 0; d_addr = 16'h0010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      d_req = 0; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'hFFFF;
      wait_drain();
      repeat (4) @(negedge clk);
      d_wr = 0;
      chk("d_rdata_held", 32'(d_rdata), 32'hA5A5);
      chk("mem_0100_intact", 32'(mem[16'h0100]), 32'h1234);

      chk("resp_queue_empty", 32'(rq.size()), 32'd0);
      chk("acc_queue_empty", 32'(aq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
